// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor, one decimal digit per clock, LSD first.
// Subtraction adds the nines' complement of B with an inverted borrow-in.
module bcd_serial_addsub #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic [4*DIGITS-1:0]   s,
    output logic                  cout,
    output logic                  busy,
    output logic                  done,
    output logic                  invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          sub_q;
    logic [CW-1:0] cnt;
    logic          c;

    logic [3:0]    a_dig;
    logic [3:0]    b_dig;
    logic [3:0]    b_eff;
    logic [4:0]    t;
    logic [4:0]    t_adj;
    logic          gt9;
    logic [3:0]    s_dig;
    logic          last;

    function automatic logic has_bad(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt == CW'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
    end

    // Nines' complement wraps mod 16 so invalid digits still give a defined value.
    assign b_eff = sub_q ? (4'd9 - b_dig) : b_dig;
    assign t     = {1'b0, a_dig} + {1'b0, b_eff} + {4'd0, c};
    assign t_adj = t + 5'd6;
    assign gt9   = (t > 5'd9);
    assign s_dig = gt9 ? t_adj[3:0] : t[3:0];
    assign last  = (cnt == CW'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            cnt     <= '0;
            c       <= 1'b0;
            s       <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            invalid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        sub_q   <= sub;
                        cnt     <= '0;
                        c       <= sub ? ~cin : cin;
                        invalid <= has_bad(a) | has_bad(b);
                        s       <= '0;
                        cout    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (cnt == CW'(i)) begin
                            s[4*i +: 4] <= s_dig;
                        end
                    end
                    c <= gt9;
                    if (last) begin
                        cnt   <= '0;
                        cout  <= gt9;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: three instances (1, 3 and 8 digits) share one
// stimulus bus; results are compared against a decimal-arithmetic model.
module tb_bcd_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic        cin;
    logic [31:0] a_in;
    logic [31:0] b_in;
    int          sel;

    logic        start1, start3, start8;
    logic [3:0]  s1;
    logic [11:0] s3;
    logic [31:0] s8;
    logic        cout1, cout3, cout8;
    logic        busy1, busy3, busy8;
    logic        done1, done3, done8;
    logic        inv1, inv3, inv8;

    logic [31:0] s_sel;
    logic        cout_sel, busy_sel, done_sel, inv_sel;

    int nvec = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    assign start1 = start && (sel == 1);
    assign start3 = start && (sel == 3);
    assign start8 = start && (sel == 8);

    assign s_sel    = (sel == 1) ? {28'd0, s1} : (sel == 3) ? {20'd0, s3} : s8;
    assign cout_sel = (sel == 1) ? cout1 : (sel == 3) ? cout3 : cout8;
    assign busy_sel = (sel == 1) ? busy1 : (sel == 3) ? busy3 : busy8;
    assign done_sel = (sel == 1) ? done1 : (sel == 3) ? done3 : done8;
    assign inv_sel  = (sel == 1) ? inv1  : (sel == 3) ? inv3  : inv8;

    bcd_serial_addsub #(.DIGITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub), .cin(cin),
        .a(a_in[3:0]), .b(b_in[3:0]), .s(s1), .cout(cout1),
        .busy(busy1), .done(done1), .invalid(inv1)
    );

    bcd_serial_addsub #(.DIGITS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .sub(sub), .cin(cin),
        .a(a_in[11:0]), .b(b_in[11:0]), .s(s3), .cout(cout3),
        .busy(busy3), .done(done3), .invalid(inv3)
    );

    bcd_serial_addsub #(.DIGITS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub), .cin(cin),
        .a(a_in), .b(b_in), .s(s8), .cout(cout8),
        .busy(busy8), .done(done8), .invalid(inv8)
    );

    function automatic longint pow10(input int d);
        longint r = 1;
        for (int i = 0; i < d; i++) r = r * 10;
        return r;
    endfunction

    function automatic longint to_int(input int d, input logic [31:0] v);
        longint r = 0;
        for (int i = d - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int d, input longint x);
        logic [31:0] v = '0;
        longint y = x;
        for (int i = 0; i < d; i++) begin
            v[4*i +: 4] = 4'(y % 10);
            y = y / 10;
        end
        return v;
    endfunction

    function automatic logic [31:0] rand_bcd(input int d);
        logic [31:0] v = '0;
        for (int i = 0; i < d; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic model(input int d, input logic [31:0] av, input logic [31:0] bv,
                         input logic sb, input logic ci,
                         output logic [31:0] es, output logic ec);
        longint m = pow10(d);
        longint r;
        if (!sb) begin
            r  = to_int(d, av) + to_int(d, bv) + longint'(ci);
            ec = (r >= m);
            es = to_bcd(d, r % m);
        end else begin
            r  = to_int(d, av) - to_int(d, bv) - longint'(ci);
            ec = (r >= 0);
            es = to_bcd(d, (r + m) % m);
        end
    endtask

    // Drives one accepted operation and reports what the selected DUT produced.
    task automatic run_op(input int d, input logic [31:0] av, input logic [31:0] bv,
                          input logic sb, input logic ci,
                          output logic [31:0] rs, output logic rc, output logic ri,
                          output int lat, output logic bsy0, output logic idle_after);
        sel   = d;
        a_in  = av;
        b_in  = bv;
        sub   = sb;
        cin   = ci;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bsy0  = busy_sel;
        lat   = 0;
        while (done_sel !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = s_sel;
        rc = cout_sel;
        ri = inv_sel;
        @(posedge clk); #1;
        idle_after = (busy_sel === 1'b0) && (done_sel === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        sel = 3; a_in = '0; b_in = '0; sub = 1'b0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if ({s3, cout3, busy3, done3, inv3} !== 16'd0) begin
            $display("FAIL reset_state: got s=%h cout=%b busy=%b done=%b inv=%b, want all 0",
                     s3, cout3, busy3, done3, inv3);
            nbad++;
        end
        start = 1'b1;
        @(posedge clk); #1;
        nvec++;
        if (busy3 !== 1'b0) begin
            $display("FAIL reset_beats_start: got busy=%b, want 0", busy3);
            nbad++;
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [5] = '{32'h100, 32'h999, 32'h999, 32'h325, 32'h100};
        logic [31:0] tb [5] = '{32'h225, 32'h999, 32'h999, 32'h100, 32'h225};
        logic        tsb[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        tci[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] es [5] = '{32'h325, 32'h999, 32'h998, 32'h225, 32'h875};
        logic        ec [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] rs;
        logic rc, ri, b0, ia;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(3, ta[i], tb[i], tsb[i], tci[i], rs, rc, ri, lat, b0, ia);
            nvec++;
            if (rs !== es[i] || rc !== ec[i] || ri !== 1'b0) begin
                $display("FAIL directed_%0d: got s=%h cout=%b inv=%b, want s=%h cout=%b inv=0",
                         i, rs, rc, ri, es[i], ec[i]);
                nbad++;
            end
            nvec++;
            if (lat != 3 || b0 !== 1'b1 || ia !== 1'b1) begin
                $display("FAIL timing_%0d: got lat=%0d busy=%b idle_after=%b, want 3 1 1",
                         i, lat, b0, ia);
                nbad++;
            end
        end
    endtask

    task automatic test_invalid();
        logic [31:0] rs, held;
        logic rc, ri, b0, ia;
        int lat;
        run_op(3, 32'h1A0, 32'h001, 1'b0, 1'b0, rs, rc, ri, lat, b0, ia);
        nvec++;
        if (ri !== 1'b1 || lat != 3) begin
            $display("FAIL invalid_flag: got inv=%b lat=%0d, want 1 3", ri, lat);
            nbad++;
        end
        held = rs;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if (inv3 !== 1'b1 || {20'd0, s3} !== held || cout3 !== rc) begin
            $display("FAIL idle_hold: got inv=%b s=%h cout=%b, want 1 %h %b",
                     inv3, s3, cout3, held, rc);
            nbad++;
        end
        run_op(3, 32'h123, 32'h001, 1'b0, 1'b0, rs, rc, ri, lat, b0, ia);
        nvec++;
        if (ri !== 1'b0 || rs !== 32'h124 || rc !== 1'b0) begin
            $display("FAIL invalid_clear: got inv=%b s=%h cout=%b, want 0 124 0", ri, rs, rc);
            nbad++;
        end
    endtask

    task automatic test_handshake();
        int ndone = 0;
        sel = 3; a_in = 32'h123; b_in = 32'h456; sub = 1'b0; cin = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        a_in = 32'h999;
        b_in = 32'h999;
        repeat (4) begin
            @(posedge clk); #1;
            if (done3 === 1'b1) ndone++;
        end
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done3 === 1'b1) ndone++;
        end
        nvec++;
        if (ndone != 1) begin
            $display("FAIL one_done_per_start: got %0d done pulses, want 1", ndone);
            nbad++;
        end
        nvec++;
        if (s3 !== 12'h579 || cout3 !== 1'b0 || busy3 !== 1'b0) begin
            $display("FAIL operand_latch: got s=%h cout=%b busy=%b, want 579 0 0",
                     s3, cout3, busy3);
            nbad++;
        end
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        sel = 3; a_in = 32'h456; b_in = 32'h544; sub = 1'b0; cin = 1'b1;
        start = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (done3 === 1'b1) ndone++;
        end
        start = 1'b0;
        nvec++;
        if (ndone != 2 || s3 !== 12'h001 || cout3 !== 1'b1 || busy3 !== 1'b0) begin
            $display("FAIL back_to_back: got dones=%0d s=%h cout=%b busy=%b, want 2 001 1 0",
                     ndone, s3, cout3, busy3);
            nbad++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rs;
        logic rc, ri, b0, ia;
        int lat;
        int ndone = 0;
        sel = 3; a_in = 32'h456; b_in = 32'h123; sub = 1'b0; cin = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        nvec++;
        if ({s3, cout3, busy3, done3, inv3} !== 16'd0) begin
            $display("FAIL reset_mid_run: got s=%h cout=%b busy=%b done=%b inv=%b, want all 0",
                     s3, cout3, busy3, done3, inv3);
            nbad++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (done3 === 1'b1) ndone++;
        end
        nvec++;
        if (ndone != 0) begin
            $display("FAIL no_done_after_abort: got %0d pulses, want 0", ndone);
            nbad++;
        end
        run_op(3, 32'h456, 32'h123, 1'b0, 1'b0, rs, rc, ri, lat, b0, ia);
        nvec++;
        if (rs !== 32'h579 || rc !== 1'b0 || lat != 3) begin
            $display("FAIL restart_after_reset: got s=%h cout=%b lat=%0d, want 579 0 3",
                     rs, rc, lat);
            nbad++;
        end
    endtask

    task automatic test_digits_edge();
        logic [31:0] rs;
        logic rc, ri, b0, ia;
        int lat;
        run_op(1, 32'h5, 32'h7, 1'b0, 1'b0, rs, rc, ri, lat, b0, ia);
        nvec++;
        if (rs !== 32'h2 || rc !== 1'b1 || lat != 1 || ia !== 1'b1) begin
            $display("FAIL digits1_add: got s=%h cout=%b lat=%0d, want 2 1 1", rs, rc, lat);
            nbad++;
        end
        run_op(8, 32'h99999999, 32'h00000000, 1'b0, 1'b1, rs, rc, ri, lat, b0, ia);
        nvec++;
        if (rs !== 32'h0 || rc !== 1'b1 || lat != 8) begin
            $display("FAIL digits8_carry: got s=%h cout=%b lat=%0d, want 0 1 8", rs, rc, lat);
            nbad++;
        end
        run_op(8, 32'h00000000, 32'h00000000, 1'b1, 1'b1, rs, rc, ri, lat, b0, ia);
        nvec++;
        if (rs !== 32'h99999999 || rc !== 1'b0) begin
            $display("FAIL digits8_borrow: got s=%h cout=%b, want 99999999 0", rs, rc);
            nbad++;
        end
    endtask

    task automatic test_random();
        int ds[3] = '{1, 3, 8};
        logic [31:0] av, bv, rs, es;
        logic sb, ci, rc, ri, b0, ia, ec;
        int lat;
        foreach (ds[k]) begin
            for (int n = 0; n < 25; n++) begin
                av = rand_bcd(ds[k]);
                bv = rand_bcd(ds[k]);
                sb = 1'($urandom_range(0, 1));
                ci = 1'($urandom_range(0, 1));
                model(ds[k], av, bv, sb, ci, es, ec);
                run_op(ds[k], av, bv, sb, ci, rs, rc, ri, lat, b0, ia);
                nvec++;
                if (rs !== es || rc !== ec || ri !== 1'b0 || lat != ds[k]) begin
                    $display("FAIL random_d%0d: a=%h b=%h sub=%b cin=%b got s=%h cout=%b inv=%b lat=%0d, want s=%h cout=%b inv=0 lat=%0d",
                             ds[k], av, bv, sb, ci, rs, rc, ri, lat, es, ec, ds[k]);
                    nbad++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_invalid();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        test_digits_edge();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
